// File: rtl/level_debouncer_pkg.sv
// debounce_pkg: shared state encoding and parameter defaults for the level debouncer.
//   Exports state_t (ST_LOW, ST_WAIT_HIGH, ST_HIGH, ST_WAIT_LOW),
//   SYNC_STAGES_DEF and DB_CYCLES_DEF.
package debounce_pkg;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF   = 4;
    // bit 1 carries the debounced level and bit 0 marks a qualification in progress
    typedef enum logic [1:0] {
        ST_LOW       = 2'b00,
        ST_WAIT_HIGH = 2'b01,
        ST_HIGH      = 2'b10,
        ST_WAIT_LOW  = 2'b11
    } state_t;
endpackage

// File: rtl/level_debouncer_if.sv
// level_debouncer_if: groups the raw pad input with the debounced outputs.
//   raw_in : raw, asynchronous, possibly bouncing input
//   level  : debounced level
//   busy   : high while a candidate transition is being qualified
//   master : the side that drives the pad and consumes the clean level
//   slave  : the debouncer
interface level_debouncer_if;
    logic raw_in;
    logic level;
    logic busy;
    modport master (output raw_in, input level, input busy);
    modport slave  (input raw_in, output level, output busy);
endinterface

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: plain flop chain that brings a single asynchronous bit into the clk domain.
//   clk : clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input
//   q   : synchronized output (last stage)
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge clk) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end
    assign q = ff[STAGES-1];
endmodule

// File: rtl/level_debouncer.sv
// level_debouncer: turns a bouncing pad input into a stable, clock-synchronous level.
//   clk : clock
//   rst : synchronous active-high reset
//   db  : slave modport; raw_in in, level and busy out
module level_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int CNT_W       = $clog2(DB_CYCLES)
) (
    input  logic               clk,
    input  logic               rst,
    level_debouncer_if.slave   db
);
    logic             s;
    logic             term;
    logic [CNT_W-1:0] cnt, cnt_n;
    state_t           state, state_n;
    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (db.raw_in),
        .q   (s)
    );
    assign term = (cnt == CNT_W'(DB_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOW;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // A disagreeing sample always wins over the terminal count, so a reversal
    // on the last qualifying edge falls back to the stable state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_LOW: begin
                if (s) begin
                    state_n = ST_WAIT_HIGH;
                    cnt_n   = CNT_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (!s) begin
                    state_n = ST_LOW;
                    cnt_n   = '0;
                end else if (term) begin
                    state_n = ST_HIGH;
                    cnt_n   = '0;
                end else begin
                    cnt_n   = cnt + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    state_n = ST_WAIT_LOW;
                    cnt_n   = CNT_W'(1);
                end
            end
            default: begin
                if (s) begin
                    state_n = ST_HIGH;
                    cnt_n   = '0;
                end else if (term) begin
                    state_n = ST_LOW;
                    cnt_n   = '0;
                end else begin
                    cnt_n   = cnt + CNT_W'(1);
                end
            end
        endcase
    end
    assign db.level = (state == ST_HIGH) || (state == ST_WAIT_LOW);
    assign db.busy  = (state == ST_WAIT_HIGH) || (state == ST_WAIT_LOW);
endmodule

// File: tb/tb_level_debouncer.sv
// tb_level_debouncer: scoreboard bench for level_debouncer with default parameters.
`timescale 1ns/1ps
module tb_level_debouncer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   ticks = 0;
    int   t0;
    logic [1:0] exp_q[$];
    string      name_q[$];

    level_debouncer_if bus();
    level_debouncer dut (.clk(clk), .rst(rst), .db(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // expected {level,busy} after the posedge following this drive
    task automatic step(input logic r, input logic rs, input logic el, input logic eb, input string nm);
        @(negedge clk);
        bus.raw_in = r;
        rst = rs;
        exp_q.push_back({el, eb});
        name_q.push_back(nm);
    endtask

    // a 0.2 ns high pulse that lies entirely between two posedges
    task automatic glitch(input string nm);
        @(negedge clk);
        bus.raw_in = 1'b1;
        #0.2 bus.raw_in = 1'b0;
        exp_q.push_back(2'b00);
        name_q.push_back(nm);
    endtask

    task automatic sync_mon();
        @(posedge clk);
        #2;
    endtask

    // monitor: samples once per cycle, counts rising level edges like the downstream edge detector
    initial begin
        logic [1:0] e;
        string      nm;
        logic       prev_level;
        prev_level = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.level === 1'b1 && prev_level === 1'b0) ticks++;
            prev_level = bus.level;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, int'({bus.level, bus.busy}), int'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.raw_in = 1'b1;
        step(1, 1, 0, 0, "rst_a");
        step(1, 1, 0, 0, "rst_b");
        sync_mon();
        check("rst_cnt", int'(dut.cnt), 0);
        t0 = ticks;
        step(1, 0, 0, 0, "rel_e1");
        step(1, 0, 0, 0, "rel_e2");
        step(1, 0, 0, 1, "rel_e3");
        step(1, 0, 0, 1, "rel_e4");
        step(1, 0, 0, 1, "rel_e5");
        step(1, 0, 1, 0, "rel_e6");
        step(1, 0, 1, 0, "rel_e7");
        step(0, 0, 1, 0, "fall_e1");
        step(0, 0, 1, 0, "fall_e2");
        step(0, 0, 1, 1, "fall_e3");
        step(0, 0, 1, 1, "fall_e4");
        step(0, 0, 1, 1, "fall_e5");
        step(0, 0, 0, 0, "fall_e6");
        step(0, 0, 0, 0, "fall_e7");
        sync_mon();
        check("rel_ticks", ticks - t0, 1);
        t0 = ticks;
        step(1, 0, 0, 0, "press_e1");
        step(1, 0, 0, 0, "press_e2");
        step(1, 0, 0, 1, "press_e3");
        step(1, 0, 0, 1, "press_e4");
        step(1, 0, 0, 1, "press_e5");
        step(1, 0, 1, 0, "press_e6");
        for (int i = 7; i <= 10; i++) step(1, 0, 1, 0, $sformatf("press_e%0d", i));
        sync_mon();
        check("press_ticks", ticks - t0, 1);
        for (int i = 1; i <= 5; i++) step(0, 0, 1, (i >= 3), $sformatf("unpress_e%0d", i));
        step(0, 0, 0, 0, "unpress_e6");
        step(0, 0, 0, 0, "unpress_e7");
        t0 = ticks;
        for (int i = 0; i < 4; i++) glitch($sformatf("glitch_%0d", i));
        step(1, 0, 0, 0, "p1_e1");
        step(0, 0, 0, 0, "p1_e2");
        step(0, 0, 0, 1, "p1_e3");
        step(0, 0, 0, 0, "p1_e4");
        step(0, 0, 0, 0, "p1_e5");
        step(1, 0, 0, 0, "p3_e1");
        step(1, 0, 0, 0, "p3_e2");
        step(1, 0, 0, 1, "p3_e3");
        step(0, 0, 0, 1, "p3_e4");
        step(0, 0, 0, 1, "p3_e5");
        step(0, 0, 0, 0, "p3_race_e6");
        sync_mon();
        check("race_cnt", int'(dut.cnt), 0);
        step(0, 0, 0, 0, "p3_e7");
        sync_mon();
        check("bounce_ticks", ticks - t0, 0);
        for (int i = 1; i <= 5; i++) step(1, 0, 0, (i >= 3), $sformatf("up_e%0d", i));
        step(1, 0, 1, 0, "up_e6");
        step(1, 0, 1, 0, "up_e7");
        step(0, 0, 1, 0, "rb_e1");
        step(0, 0, 1, 0, "rb_e2");
        step(1, 0, 1, 1, "rb_e3");
        step(1, 0, 1, 1, "rb_e4");
        step(0, 0, 1, 0, "rb_e5");
        step(0, 0, 1, 0, "rb_e6");
        step(0, 0, 1, 1, "rb_e7");
        step(0, 0, 1, 1, "rb_e8");
        step(0, 0, 1, 1, "rb_e9");
        step(0, 0, 0, 0, "rb_e10");
        step(0, 0, 0, 0, "rb_e11");
        step(1, 0, 0, 0, "mq_e1");
        step(1, 0, 0, 0, "mq_e2");
        step(1, 0, 0, 1, "mq_e3");
        step(1, 0, 0, 1, "mq_e4");
        sync_mon();
        check("mq_cnt", int'(dut.cnt), 2);
        step(1, 1, 0, 0, "mq_rst");
        sync_mon();
        check("mq_rst_cnt", int'(dut.cnt), 0);
        for (int i = 1; i <= 5; i++) step(1, 0, 0, (i >= 3), $sformatf("mq_re_e%0d", i));
        step(1, 0, 1, 0, "mq_re_e6");
        sync_mon();
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
